can_crc_transmitter: RTL and testbench



---
 rtl/can_crc_transmitter.sv | 154 +++++++++++++++
 tb/tb_can_crc_transmitter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/can_crc_transmitter.sv
// CAN CRC-15 transmitter: hashes the serialized frame bits, then sends the
// 15 CRC bits MSB-first and the recessive delimiter, one bit per slot.
//
// state | meaning
// IDLE  | bus recessive, waiting for Start
// DATA  | forwarding frame bits and updating the CRC, one per slot
// CRC   | shifting out CRC[14..0], CRC register frozen
// DELIM | recessive CRC delimiter slot, Done at its end
module can_crc_transmitter #(
  parameter int crc_CLKS_PER_BIT = 10
) (
  input  logic        Clock_TB,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        Bit_In,
  input  logic        Last_In,
  output logic        Bit_Ack,
  output logic        Tx_Bit,
  output logic        Busy,
  output logic        Done,
  output logic [14:0] CRC_Value
);

  localparam int CNT_W = (crc_CLKS_PER_BIT > 2) ? $clog2(crc_CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(crc_CLKS_PER_BIT - 1);
  localparam logic [14:0] CRC_POLY = 15'h4599;
  localparam logic [3:0]  IDX_TOP  = 4'd14;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_CRC   = 2'd2;
  localparam logic [1:0] ST_DELIM = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [14:0]      crc_q, crc_d;
  logic             last_q, last_d;
  logic             tx_q, tx_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic slot_start;
  logic slot_end;
  logic crc_fb;

  assign slot_start = (cnt_q == '0);
  assign slot_end   = (cnt_q == CNT_LAST);
  assign crc_fb     = Bit_In ^ crc_q[14];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    crc_d   = crc_q;
    last_d  = last_q;
    tx_d    = tx_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Timer idles at 0 so the cycle after Start is always a slot start.
    if (state_q == ST_IDLE || slot_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (Start) begin
          state_d = ST_DATA;
          crc_d   = '0;
          idx_d   = IDX_TOP;
          last_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_DATA: begin
        if (slot_start) begin
          tx_d   = Bit_In;
          ack_d  = 1'b1;
          last_d = Last_In;
          crc_d  = {crc_q[13:0], 1'b0} ^ (crc_fb ? CRC_POLY : 15'h0000);
        end
        if (slot_end && last_q) begin
          state_d = ST_CRC;
          idx_d   = IDX_TOP;
        end
      end
      ST_CRC: begin
        if (slot_start) begin
          tx_d = crc_q[idx_q];
        end
        // Index steps at slot end; the bit it selects goes out at the next slot start.
        if (slot_end) begin
          if (idx_q == 4'd0) begin
            state_d = ST_DELIM;
          end else begin
            idx_d = idx_q - 4'd1;
          end
        end
      end
      ST_DELIM: begin
        if (slot_start) begin
          tx_d = 1'b1;
        end
        if (slot_end) begin
          state_d = ST_IDLE;
          idx_d   = IDX_TOP;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock_TB or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= IDX_TOP;
      crc_q   <= '0;
      last_q  <= 1'b0;
      tx_q    <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Bit_Ack   = ack_q;
  assign Tx_Bit    = tx_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign CRC_Value = crc_q;

endmodule

// File: tb/tb_can_crc_transmitter.sv
// Directed bench for can_crc_transmitter: frames with hand-computed CRCs,
// slot-accurate timing of Bit_Ack/Done/Busy and the serialized Tx_Bit stream.
module tb_can_crc_transmitter;

  localparam int C = 10;

  logic        Clock_TB;
  logic        Reset_n;
  logic        Start;
  logic        Bit_In;
  logic        Last_In;
  logic        Bit_Ack;
  logic        Tx_Bit;
  logic        Busy;
  logic        Done;
  logic [14:0] CRC_Value;

  int n_checks = 0;
  int n_pass   = 0;

  can_crc_transmitter #(.crc_CLKS_PER_BIT(C)) dut (
    .Clock_TB  (Clock_TB),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Bit_In    (Bit_In),
    .Last_In   (Last_In),
    .Bit_Ack   (Bit_Ack),
    .Tx_Bit    (Tx_Bit),
    .Busy      (Busy),
    .Done      (Done),
    .CRC_Value (CRC_Value)
  );

  initial begin
    Clock_TB = 1'b0;
    forever #5 Clock_TB = ~Clock_TB;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // bits[k] is data slot k. Returns at the negedge of the expected Done cycle.
  task automatic run_frame(input int n, input logic [31:0] bits, input logic [14:0] exp_crc,
                           input bit pre_started, input bit tog, input bit mid_start,
                           input string tag);
    int rel, limit, ack_cnt, done_at, done_cnt, p;
    bit busy_bad;
    logic cur_bit;
    logic [63:0] obs_v, exp_v;
    limit = (n + 16) * C + 1;
    ack_cnt = 0; done_at = -1; done_cnt = 0; busy_bad = 0;
    obs_v = '0; exp_v = '0;
    for (int s = 0; s < n + 16; s++) begin
      if (s < n) exp_v[s] = bits[s];
      else if (s < n + 15) exp_v[s] = exp_crc[14 - (s - n)];
      else exp_v[s] = 1'b1;
    end
    cur_bit = bits[0];
    if (!pre_started) begin
      @(negedge Clock_TB);
      Start = 1'b1; Bit_In = cur_bit; Last_In = (n == 1);
    end
    @(posedge Clock_TB);
    #1;
    Start = 1'b0;
    for (rel = 1; rel <= limit; rel++) begin
      @(negedge Clock_TB);
      p = (rel - 1) % C;
      if (Bit_Ack === 1'b1) begin
        ack_cnt++;
        if (ack_cnt < n) begin
          cur_bit = bits[ack_cnt];
          Bit_In  = cur_bit;
          Last_In = (ack_cnt == n - 1);
        end
      end
      if (tog && rel > 1 && ack_cnt < n) begin
        if (p == 4) Bit_In = ~cur_bit;
        else if (p == 7) Bit_In = cur_bit;
      end
      if (rel >= 2 && ((rel - 2) % C) == C / 2 && ((rel - 2) / C) < n + 16)
        obs_v[(rel - 2) / C] = Tx_Bit;
      if (rel == 2 + n * C) check({tag, "_crc_first_slot"}, 64'(CRC_Value), 64'(exp_crc));
      if (Done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = rel;
      end
      if (rel < limit && Busy !== 1'b1) busy_bad = 1;
      if (mid_start) begin
        if (rel == 2 + (n + 3) * C) Start = 1'b1;
        else if (rel == 3 + (n + 3) * C) Start = 1'b0;
      end
    end
    check({tag, "_done_cycle"}, 64'(done_at), 64'(limit));
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_at_done"}, 64'(Busy), 64'd0);
    check({tag, "_busy_held"}, 64'(busy_bad), 64'd0);
    check({tag, "_ack_count"}, 64'(ack_cnt), 64'(n));
    check({tag, "_tx_stream"}, obs_v, exp_v);
    check({tag, "_crc_final"}, 64'(CRC_Value), 64'(exp_crc));
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Bit_In = 1'b0; Last_In = 1'b0;
    repeat (3) @(negedge Clock_TB);
    check("rst_tx", 64'(Tx_Bit), 64'd1);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_ack", 64'(Bit_Ack), 64'd0);
    check("rst_crc", 64'(CRC_Value), 64'd0);
    Reset_n = 1'b1;

    // Reset in the middle of DATA: outputs must drop asynchronously.
    @(negedge Clock_TB);
    Start = 1'b1; Bit_In = 1'b1; Last_In = 1'b0;
    @(posedge Clock_TB);
    #1;
    Start = 1'b0;
    repeat (25) @(negedge Clock_TB);
    check("mid_busy_before_rst", 64'(Busy), 64'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("mid_rst_tx", 64'(Tx_Bit), 64'd1);
    check("mid_rst_busy", 64'(Busy), 64'd0);
    check("mid_rst_done", 64'(Done), 64'd0);
    check("mid_rst_ack", 64'(Bit_Ack), 64'd0);
    check("mid_rst_crc", 64'(CRC_Value), 64'd0);
    repeat (2) @(negedge Clock_TB);
    Reset_n = 1'b1; Bit_In = 1'b0; Last_In = 1'b0;
    repeat (3) @(negedge Clock_TB);
    check("post_rst_idle_busy", 64'(Busy), 64'd0);

    run_frame(1, 32'h1, 15'h4599, 0, 0, 0, "n1");
    run_frame(2, 32'h1, 15'h4EAB, 0, 0, 0, "n2");
    run_frame(8, 32'h0, 15'h0000, 0, 0, 0, "n8_zero");
    run_frame(3, 32'h5, 15'h1D56, 0, 0, 1, "start_in_crc");
    run_frame(3, 32'h5, 15'h1D56, 0, 1, 0, "toggle");
    run_frame(2, 32'h1, 15'h4EAB, 0, 0, 0, "b2b_a");
    Start = 1'b1; Bit_In = 1'b1; Last_In = 1'b0;
    run_frame(2, 32'h1, 15'h4EAB, 1, 0, 0, "b2b_b");

    repeat (3) @(negedge Clock_TB);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
